ram_burst_ctrl: RTL

Burst initiator for the single-port-pair `ram` block: accepts a command (read or write, base address, length), then streams words between valid/ready client channels and the RAM's read/write ports. It owns the RAM's `cs`, `rd_en`, `wr_en` and address lines, and absorbs the RAM's registered read latency with a small output buffer, so a client sees a plain stream at one word per cycle. It sits between the datapath/loader logic and one `ram` instance.

---
 rtl/ram_burst_ctrl_pkg.sv | 18 +
 rtl/ram_burst_ctrl_if.sv | 53 +++++
 rtl/ram_burst_ctrl_rbuf.sv | 51 +++++
 rtl/ram_burst_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller.
package ram_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Read buffer depth; also bounds buffered plus in-flight reads
    localparam int unsigned RBUF_DEPTH = 4;

    // Cycles from the controller registering ram_rd_en to sampling ram_data_out
    localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Client + RAM-side bundle for ram_burst_ctrl.
// slave = controller view, master = client/RAM view.
interface ram_burst_ctrl_if
    import ram_burst_pkg::*;
#(
    parameter int unsigned WORDSIZE = 16,
    parameter int unsigned ADDRSIZE = 6,
    parameter int unsigned LENSIZE  = ADDRSIZE + 1
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDRSIZE-1:0] cmd_addr;
    logic [LENSIZE-1:0]  cmd_len;

    logic                wdata_valid;
    logic                wdata_ready;
    logic [WORDSIZE-1:0] wdata;

    logic                rdata_valid;
    logic                rdata_ready;
    logic [WORDSIZE-1:0] rdata;
    logic                rdata_last;

    logic                busy;
    logic                done;
    logic                err;

    logic                ram_cs;
    logic                ram_rd_en;
    logic                ram_wr_en;
    logic [ADDRSIZE-1:0] ram_read_addr;
    logic [ADDRSIZE-1:0] ram_write_addr;
    logic [WORDSIZE-1:0] ram_data_in;
    logic [WORDSIZE-1:0] ram_data_out;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wdata_valid, wdata, rdata_ready, ram_data_out,
        output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        output busy, done, err,
        output ram_cs, ram_rd_en, ram_wr_en, ram_read_addr, ram_write_addr, ram_data_in
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wdata_valid, wdata, rdata_ready, ram_data_out,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last,
        input  busy, done, err,
        input  ram_cs, ram_rd_en, ram_wr_en, ram_read_addr, ram_write_addr, ram_data_in
    );

endinterface

// File: rtl/ram_burst_ctrl_rbuf.sv
// 4-entry read buffer: stores data plus a last flag, valid/ready output side.
module ram_burst_rbuf
    import ram_burst_pkg::*;
#(
    parameter int unsigned WORDSIZE = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [WORDSIZE-1:0]                push_data,
    input  logic                               push_last,
    output logic                               valid,
    input  logic                               ready,
    output logic [WORDSIZE-1:0]                data,
    output logic                               last,
    output logic [$clog2(RBUF_DEPTH):0]        count
);
    localparam int unsigned PW = $clog2(RBUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WORDSIZE:0] mem [RBUF_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              pop;

    assign valid = (count != '0);
    assign pop   = valid && ready;
    // Gated so the output reads zero whenever nothing is buffered
    assign data  = valid ? mem[rd_ptr][WORDSIZE-1:0] : '0;
    assign last  = valid && mem[rd_ptr][WORDSIZE];

    // Storage write; no reset needed since valid gates the output
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_last, push_data};
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a registered-read RAM: command in, word streams out/in.
// Build option: RAM_BURST_ADDR_WRAP_EN allows bursts that run past the top
// address to wrap to 0; without it such commands are rejected with done+err.
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int unsigned WORDSIZE = 16,
    parameter int unsigned ADDRSIZE = 6,
    parameter int unsigned LENSIZE  = ADDRSIZE + 1
) (
    input  logic clk,
    input  logic rst,
    ram_burst_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(RBUF_DEPTH) + 1;

    state_t              state, next_state;
    logic [ADDRSIZE-1:0] addr;
    logic [LENSIZE-1:0]  remain;
    logic                err_q;

    logic                cs_q, rd_en_q, wr_en_q;
    logic [ADDRSIZE-1:0] rd_addr_q, wr_addr_q;
    logic [WORDSIZE-1:0] data_in_q;

    logic [RD_LATENCY-1:0] pend_vld, pend_last;
    logic [CW-1:0]         inflight, occ;
    logic [CW:0]           window;

    logic cmd_ready, wdata_ready, cmd_fire, wr_fire, issue, pop, out_of_range;
    logic rb_valid, rb_last;
    logic [WORDSIZE-1:0] rb_data;

`ifdef RAM_BURST_ADDR_WRAP_EN
    assign out_of_range = 1'b0;
`else
    logic [LENSIZE:0] end_sum;
    assign end_sum      = (LENSIZE+1)'(bus.cmd_addr) + {1'b0, bus.cmd_len};
    assign out_of_range = end_sum > (LENSIZE+1)'(2**ADDRSIZE);
`endif

    // Reads issued but not yet pushed into the buffer
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pend_vld[i]);
        end
    end

    assign window   = (CW+1)'(occ) + (CW+1)'(inflight);
    assign pop      = rb_valid && bus.rdata_ready;
    assign cmd_fire = cmd_ready && bus.cmd_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake decode
    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        wr_fire     = 1'b0;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0 || out_of_range) next_state = DONE;
                    else if (bus.cmd_write)                next_state = WRITE;
                    else                                   next_state = READ;
                end
            end
            // Holding WRITE one idle cycle after the last word puts done
            // in the cycle after the final ram_wr_en cycle.
            WRITE: begin
                wdata_ready = (remain != '0);
                wr_fire     = wdata_ready && bus.wdata_valid;
                if (remain == '0) next_state = DONE;
            end
            READ: begin
                issue = (window < (CW+1)'(RBUF_DEPTH));
                if (issue && remain == LENSIZE'(1)) next_state = DRAIN;
            end
            // Leave as the final word is handed over so done follows it directly
            DRAIN: begin
                if (inflight == '0 && (occ == '0 || (occ == CW'(1) && pop)))
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Burst bookkeeping and registered RAM controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remain    <= '0;
            err_q     <= 1'b0;
            cs_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            data_in_q <= '0;
            pend_vld  <= '0;
            pend_last <= '0;
        end else begin
            cs_q      <= (next_state != IDLE);
            rd_en_q   <= issue;
            wr_en_q   <= wr_fire;
            pend_vld  <= {pend_vld[RD_LATENCY-2:0], issue};
            pend_last <= {pend_last[RD_LATENCY-2:0], issue && remain == LENSIZE'(1)};
            if (cmd_fire) begin
                addr   <= bus.cmd_addr;
                remain <= bus.cmd_len;
                err_q  <= out_of_range;
            end else if (wr_fire) begin
                wr_addr_q <= addr;
                data_in_q <= bus.wdata;
                addr      <= addr + ADDRSIZE'(1);
                remain    <= remain - LENSIZE'(1);
            end else if (issue) begin
                rd_addr_q <= addr;
                addr      <= addr + ADDRSIZE'(1);
                remain    <= remain - LENSIZE'(1);
            end
        end
    end

    ram_burst_rbuf #(
        .WORDSIZE (WORDSIZE)
    ) u_rbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_vld[RD_LATENCY-1]),
        .push_data (bus.ram_data_out),
        .push_last (pend_last[RD_LATENCY-1]),
        .valid     (rb_valid),
        .ready     (bus.rdata_ready),
        .data      (rb_data),
        .last      (rb_last),
        .count     (occ)
    );

    assign bus.cmd_ready      = cmd_ready;
    assign bus.wdata_ready    = wdata_ready;
    assign bus.rdata_valid    = rb_valid;
    assign bus.rdata          = rb_data;
    assign bus.rdata_last     = rb_last;
    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == DONE);
    assign bus.err            = (state == DONE) && err_q;
    assign bus.ram_cs         = cs_q;
    assign bus.ram_rd_en      = rd_en_q;
    assign bus.ram_wr_en      = wr_en_q;
    assign bus.ram_read_addr  = rd_addr_q;
    assign bus.ram_write_addr = wr_addr_q;
    assign bus.ram_data_in    = data_in_q;

endmodule
